// File: rtl/braille_display_driver.sv
// braille_display_driver: serialises six 6-dot braille cells to an actuator driver chain.
// Rev 1.0 -- initial release.
`default_nettype none

module braille_display_driver #(
  parameter int CLK_DIV      = 4,
  parameter bit AUTO_REFRESH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] h_l,
  input  logic [5:0] h_r,
  input  logic [5:0] m_l,
  input  logic [5:0] m_r,
  input  logic [5:0] s_l,
  input  logic [5:0] s_r,
  input  logic       refresh,
  output logic       sclk,
  output logic       sdata,
  output logic       latch,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] C_LAST_BIT = 6'd35;

  state_t      r_state;
  state_t      w_next;
  logic [35:0] r_shift;
  logic [35:0] r_snap;
  logic [35:0] r_last_sent;
  logic [7:0]  r_div;
  logic [5:0]  r_bit;
  logic        r_pending;

  logic [35:0] w_frame;
  logic        w_div_end;
  logic        w_start;
  logic        w_busy_trig;

  assign w_frame   = {h_l, h_r, m_l, m_r, s_l, s_r};
  assign w_div_end = (r_div == C_DIV_LAST);
  assign w_start   = refresh || r_pending || (AUTO_REFRESH && (w_frame != r_last_sent));
  // While busy, an input change is judged against the frame being sent, so an
  // unchanged frame never queues a redundant follow-up transfer.
  assign w_busy_trig = refresh || (AUTO_REFRESH && (w_frame != r_snap));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    sclk   = 1'b0;
    sdata  = 1'b0;
    latch  = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_start) w_next = SHIFT_LO;
      end
      SHIFT_LO: begin
        sdata = r_shift[35];
        if (w_div_end) w_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        sclk  = 1'b1;
        sdata = r_shift[35];
        if (w_div_end) w_next = (r_bit == C_LAST_BIT) ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        latch = 1'b1;
        if (w_div_end) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_snap      <= '0;
      r_last_sent <= '0;
      r_div       <= '0;
      r_bit       <= '0;
      r_pending   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_div <= '0;
          r_bit <= '0;
          if (w_start) begin
            r_shift   <= w_frame;
            r_snap    <= w_frame;
            r_pending <= 1'b0;
          end
        end
        SHIFT_LO, LATCH: begin
          r_div <= w_div_end ? 8'd0 : r_div + 8'd1;
        end
        SHIFT_HI: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_bit   <= r_bit + 6'd1;
            r_shift <= {r_shift[34:0], 1'b0};
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        DONE: begin
          r_last_sent <= r_snap;
        end
        default: ;
      endcase
      if (r_state != IDLE && w_busy_trig) r_pending <= 1'b1;
    end
  end

endmodule

`default_nettype wire
